// File: rtl/line_fill_engine.sv
// Critical-word-first cache line refill from slow main memory into the L1 array.
// Main-memory delay is modelled by a per-word latency counter on the core clock.
module line_fill_engine #(
    parameter int WORDS_PER_LINE = 8,
    parameter int MM_LATENCY     = 8,
    parameter int ADDR_W         = 14
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              busy,
    output logic              mm_re,
    output logic [ADDR_W-1:0] mm_addr,
    input  logic [31:0]       mm_data,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [31:0]       fill_data,
    output logic              crit_valid,
    output logic              fill_last,
    output logic              fill_done
);
    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int LW = (MM_LATENCY > 1) ? $clog2(MM_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(MM_LATENCY - 1);
    localparam logic [OW-1:0] WC_LAST  = OW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               r_state, w_next;
    logic [ADDR_W-OW-1:0] r_tag;
    logic [OW-1:0]        r_off;
    logic [OW-1:0]        r_wcnt;
    logic [LW-1:0]        r_lat;
    logic [31:0]          r_data;
    logic [ADDR_W-1:0]    w_addr;

    // Offset is only OW bits wide, so incrementing it wraps inside the line.
    assign w_addr = {r_tag, r_off};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (req_valid) w_next = READ;
            READ:  if (r_lat == LAT_LAST) w_next = WRITE;
            WRITE: w_next = (r_wcnt == WC_LAST) ? DONE : READ;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tag  <= '0;
            r_off  <= '0;
            r_wcnt <= '0;
            r_lat  <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_tag  <= req_addr[ADDR_W-1:OW];
                    r_off  <= req_addr[OW-1:0];
                    r_wcnt <= '0;
                    r_lat  <= '0;
                end
                READ: begin
                    r_lat <= r_lat + 1'b1;
                    if (r_lat == LAT_LAST) r_data <= mm_data;
                end
                WRITE: begin
                    r_off  <= r_off + 1'b1;
                    r_wcnt <= r_wcnt + 1'b1;
                    r_lat  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = (r_state == IDLE);
        busy       = (r_state != IDLE);
        mm_re      = 1'b0;
        mm_addr    = w_addr;
        fill_we    = 1'b0;
        fill_addr  = w_addr;
        fill_data  = r_data;
        crit_valid = 1'b0;
        fill_last  = 1'b0;
        fill_done  = 1'b0;
        case (r_state)
            READ:  mm_re = 1'b1;
            WRITE: begin
                fill_we    = 1'b1;
                crit_valid = (r_wcnt == '0);
                fill_last  = (r_wcnt == WC_LAST);
            end
            DONE:  fill_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench: default engine (8 words, latency 8) and a small one (4 words, latency 1)
// against a main-memory model that drives garbage except on the last latency cycle.
module tb_line_fill_engine;
    logic        CLK, RST_N;
    logic        req_valid0, req_valid1;
    logic [13:0] req_addr0, req_addr1;
    logic        req_ready0, busy0, mm_re0, fill_we0, crit0, last0, done0;
    logic        req_ready1, busy1, mm_re1, fill_we1, crit1, last1, done1;
    logic [13:0] mm_addr0, fill_addr0, mm_addr1, fill_addr1;
    logic [31:0] mm_data0, fill_data0, mm_data1, fill_data1;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt0 = 0, cnt1 = 0;
    logic [13:0] got_addr [16];

    logic        s_ready, s_busy, s_mmre, s_we, s_crit, s_last, s_done;
    logic [13:0] s_mmaddr, s_faddr;
    logic [31:0] s_fdata;

    line_fill_engine u0 (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid0), .req_addr(req_addr0),
        .req_ready(req_ready0), .busy(busy0), .mm_re(mm_re0), .mm_addr(mm_addr0),
        .mm_data(mm_data0), .fill_we(fill_we0), .fill_addr(fill_addr0),
        .fill_data(fill_data0), .crit_valid(crit0), .fill_last(last0), .fill_done(done0)
    );

    line_fill_engine #(.WORDS_PER_LINE(4), .MM_LATENCY(1), .ADDR_W(14)) u1 (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid1), .req_addr(req_addr1),
        .req_ready(req_ready1), .busy(busy1), .mm_re(mm_re1), .mm_addr(mm_addr1),
        .mm_data(mm_data1), .fill_we(fill_we1), .fill_addr(fill_addr1),
        .fill_data(fill_data1), .crit_valid(crit1), .fill_last(last1), .fill_done(done1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem(input logic [13:0] a);
        return {a, 2'b01, a[7:0], ~a[7:0]};
    endfunction

    // Memory model: real data only on the L-th consecutive mm_re cycle.
    always @(negedge CLK) begin
        cnt0 = mm_re0 ? cnt0 + 1 : 0;
        mm_data0 = (cnt0 == 8) ? mem(mm_addr0) : 32'hBAD0_0000 | cnt0;
        cnt1 = mm_re1 ? cnt1 + 1 : 0;
        mm_data1 = (cnt1 == 1) ? mem(mm_addr1) : 32'hBAD1_0000 | cnt1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample(input int inst);
        if (inst == 0) begin
            s_ready = req_ready0; s_busy = busy0; s_mmre = mm_re0; s_mmaddr = mm_addr0;
            s_we = fill_we0; s_faddr = fill_addr0; s_fdata = fill_data0;
            s_crit = crit0; s_last = last0; s_done = done0;
        end else begin
            s_ready = req_ready1; s_busy = busy1; s_mmre = mm_re1; s_mmaddr = mm_addr1;
            s_we = fill_we1; s_faddr = fill_addr1; s_fdata = fill_data1;
            s_crit = crit1; s_last = last1; s_done = done1;
        end
    endtask

    task automatic drive(input int inst, input logic v, input logic [13:0] a);
        if (inst == 0) begin req_valid0 = v; req_addr0 = a; end
        else           begin req_valid1 = v; req_addr1 = a; end
    endtask

    task automatic chk_rst(input int inst);
        sample(inst);
        chk("rst_ready", s_ready, 1); chk("rst_busy", s_busy, 0);
        chk("rst_mmre", s_mmre, 0);   chk("rst_mmaddr", s_mmaddr, 0);
        chk("rst_we", s_we, 0);       chk("rst_faddr", s_faddr, 0);
        chk("rst_fdata", s_fdata, 0); chk("rst_crit", s_crit, 0);
        chk("rst_last", s_last, 0);   chk("rst_done", s_done, 0);
    endtask

    // Accept a request and check every cycle of the fill; cycle c ends at edge c.
    task automatic run_fill(input int inst, input logic [13:0] addr, input int hold_at,
                            input logic [13:0] hold_addr, input int stop_at);
        int W, L, n, k, start, wc;
        logic [13:0] base, ea;
        W = (inst == 0) ? 8 : 4;
        L = (inst == 0) ? 8 : 1;
        wc = W * (L + 1);
        base = addr & 14'(~(W - 1));
        start = int'(addr) & (W - 1);
        n = 0;
        sample(inst);
        while (!s_ready && n < 200) begin
            @(posedge CLK); #1; sample(inst); n++;
        end
        chk("ready_wait", s_ready, 1);
        drive(inst, 1'b1, addr);
        @(posedge CLK); #1;
        drive(inst, 1'b0, 14'h0);
        for (int c = 1; c <= wc + 1; c++) begin
            sample(inst);
            chk("busy", s_busy, 1);
            chk("fill_done", s_done, c == wc + 1);
            if (c % (L + 1) == 0) begin
                k = c / (L + 1) - 1;
                ea = base | 14'((start + k) % W);
                chk("fill_we", s_we, 1);
                chk("mm_re_wr", s_mmre, 0);
                chk("fill_addr", s_faddr, ea);
                chk("fill_data", s_fdata, mem(ea));
                chk("crit_valid", s_crit, k == 0);
                chk("fill_last", s_last, k == W - 1);
                got_addr[k] = s_faddr;
            end else begin
                chk("fill_we_idle", s_we, 0);
                if (c <= wc) begin
                    k = (c - 1) / (L + 1);
                    chk("mm_re", s_mmre, 1);
                    chk("mm_addr", s_mmaddr, base | 14'((start + k) % W));
                end
            end
            if (stop_at != 0 && c == stop_at) return;
            if (c == hold_at) drive(inst, 1'b1, hold_addr);
            @(posedge CLK); #1;
        end
        sample(inst);
        chk("ready_back", s_ready, 1);
    endtask

    initial begin
        logic [13:0] exp8 [8];
        logic [13:0] exp4 [4];
        int n;
        logic saw_we;
        RST_N = 1'b0;
        drive(0, 1'b1, 14'h010);
        drive(1, 1'b0, 14'h0);
        repeat (3) @(posedge CLK);
        #1;
        chk_rst(0);
        chk_rst(1);
        @(negedge CLK) RST_N = 1'b1;

        run_fill(0, 14'h010, 0, 14'h0, 0);
        exp8 = '{14'h010, 14'h011, 14'h012, 14'h013, 14'h014, 14'h015, 14'h016, 14'h017};
        for (int i = 0; i < 8; i++) chk("seq_lin", got_addr[i], exp8[i]);

        run_fill(0, 14'h013, 0, 14'h0, 0);
        exp8 = '{14'h013, 14'h014, 14'h015, 14'h016, 14'h017, 14'h010, 14'h011, 14'h012};
        for (int i = 0; i < 8; i++) chk("seq_wrap", got_addr[i], exp8[i]);

        // Request for 0x100 raised mid-fill and held; taken at edge 74.
        run_fill(0, 14'h010, 20, 14'h100, 0);
        @(posedge CLK); #1;
        sample(0);
        chk("held_accept", s_busy, 1);
        chk("held_addr", s_mmaddr, 14'h100);
        drive(0, 1'b0, 14'h0);
        n = 0;
        sample(0);
        while (!s_ready && n < 200) begin
            @(posedge CLK); #1; sample(0); n++;
        end
        chk("held_finish", s_ready, 1);

        // Reset during READ of word 3.
        run_fill(0, 14'h020, 0, 14'h0, 30);
        #2 RST_N = 1'b0;
        #1 chk_rst(0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        saw_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (fill_we0 || busy0) saw_we = 1'b1;
        end
        chk("post_rst_quiet", saw_we, 0);
        run_fill(0, 14'h025, 0, 14'h0, 0);
        exp8 = '{14'h025, 14'h026, 14'h027, 14'h020, 14'h021, 14'h022, 14'h023, 14'h024};
        for (int i = 0; i < 8; i++) chk("seq_after_rst", got_addr[i], exp8[i]);

        run_fill(1, 14'h002, 0, 14'h0, 0);
        exp4 = '{14'h002, 14'h003, 14'h000, 14'h001};
        for (int i = 0; i < 4; i++) chk("seq_l1", got_addr[i], exp4[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/line_fill_engine.md
# line_fill_engine

Miss-service engine between the L1 instruction cache controller and the slow main memory. On a miss request it reads one full cache line from main memory, critical word first with wrap-around inside the line. Each word is written into the L1 array as it arrives, and the critical word is flagged so fetch can restart early. A per-word latency counter models main-memory delay on the single core clock, replacing the divided memory clock.

## Interface
- WORDS_PER_LINE, 8: words per line; power of two, 2..16
- MM_LATENCY, 8: cycles main memory needs per word read; ≥1
- ADDR_W, 14: word-address width (PC[15:2])
- CLK  in  1  core clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- req_valid  in  1  miss request from cache controller
- req_addr  in  ADDR_W  missing word address
- req_ready  out  1  engine idle, request will be accepted
- busy  out  1  fill in progress (state ≠ IDLE)
- mm_re  out  1  main-memory read enable
- mm_addr  out  ADDR_W  main-memory word address
- mm_data  in  32  main-memory read data, valid on last latency cycle
- fill_we  out  1  one-cycle L1 write strobe
- fill_addr  out  ADDR_W  L1 word address being filled
- fill_data  out  32  L1 write data
- crit_valid  out  1  current fill word is the requested (critical) word
- fill_last  out  1  current fill word is the last of the line
- fill_done  out  1  one-cycle pulse, line complete

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: req_ready=1. On req_valid, latch base = req_addr with low log2(WORDS_PER_LINE) bits cleared, offset = req_addr low bits, start_off = offset, word count = 0, latency count = 0. Go to READ.
- READ: mm_re=1, mm_addr = base | offset, held stable. Latency counter increments each cycle. On count == MM_LATENCY-1, capture mm_data into the fill register and go to WRITE.
- WRITE, exactly one cycle:
  - fill_we=1, fill_addr = base | offset, fill_data = captured word, mm_re=0.
  - crit_valid=1 iff word count == 0. fill_last=1 iff word count == WORDS_PER_LINE-1.
  - Then offset = (offset+1) mod WORDS_PER_LINE (wraps within the line, never into the next line), word count +1, latency count = 0.
  - Go to DONE if the last word was written, else READ.
- DONE: fill_done=1 for one cycle, then IDLE.
- Requests are ignored while busy. No queuing.
- Output decode: outputs are decoded from registered state/counters only. No combinational path from inputs to outputs. Exception: req_ready = (state==IDLE).
- Reset (RST_N low, any time, including mid-fill):
  - State = IDLE, all counters = 0, fill register = 0.
  - Outputs: req_ready=1, busy=0, mm_re=0, mm_addr=0, fill_we=0, fill_addr=0, fill_data=0, crit_valid=0, fill_last=0, fill_done=0.
  - A partially filled line is abandoned. The cache controller must invalidate it; the engine gives no indication.
- Every word is written exactly once per fill. Order: start_off, start_off+1, …, wrapping, ending at start_off-1.

## Timing
- Let edge 0 be the accepting edge (req_valid & req_ready). Let L = MM_LATENCY and W = WORDS_PER_LINE.
- READ for word k spans cycles k(L+1)+1 … k(L+1)+L. WRITE for word k is at cycle (k+1)(L+1).
- Critical word (crit_valid, fill_we) is at cycle L+1.
- Last word (fill_last) is at cycle W(L+1). fill_done is at W(L+1)+1. req_ready returns at W(L+1)+2.
- Defaults W=8, L=8: crit at 9, last write at 72, done at 73, next accept earliest at edge 74.
- mm_re falls for exactly one cycle (WRITE) between consecutive words. mm_addr changes only on WRITE→READ.
- L=1: READ lasts one cycle; per-word period is 2 cycles.
- Back-to-back: a request held high through DONE is accepted on the first IDLE edge.

## Test plan
- Reset values: hold RST_N low, drive req_valid=1. Required: all outputs at reset values listed above. Release reset; req_valid=1, req_addr=0x010. Required: fill_we at cycles 9,18,…,72 with fill_addr 0x010..0x017 in order; crit_valid only at cycle 9; fill_last only at 72; fill_done at 73.
- Wrap-around: req_addr=0x013. Required: fill_addr sequence 0x013,0x014,0x015,0x016,0x017,0x010,0x011,0x012. mm_addr matches each READ. fill_data equals the model memory word at each address.
- Busy ignore: second req_valid pulse with req_addr=0x100 at cycle 20 of a fill. Required: no effect. The fill completes on the original line. After fill_done, a held request for 0x100 is accepted at edge 74.
- Reset mid-operation: assert RST_N low at cycle 30 (during READ of word 3) for 2 cycles. Required: outputs drop asynchronously to reset values. No further fill_we. A new request afterwards completes a full, correct line.
- Latency variants: MM_LATENCY=1 and WORDS_PER_LINE=4, req_addr=0x002. Required: writes to 0x002,0x003,0x000,0x001 at cycles 2,4,6,8; fill_done at 9.
- Data-sampling check: model memory drives garbage except on the final latency cycle. Required: fill_data never reflects the garbage.
